coin_acceptor: RTL and testbench
================================

// Module: coin_acceptor
// PURPOSE
//  Front end of the coin path. Takes raw, bouncy, asynchronous coin-sensor levels and turns
//  them into clean single-cycle quarter/dime/nickel pulses. These pulses drive the coin
//  counter's inQ/inD/inN inputs. It serialises coins that arrive at the same time, enforces
//  a credit ceiling, and rejects coins while inhibited (for example during change dispense).
// PARAMETERS
//  DEBOUNCE_CYCLES  4    consecutive synchronised-high samples needed to accept an insertion
//  GAP_CYCLES       1    idle cycles forced after each outQ/outD/outN/reject pulse (>=1)
//  MAX_CREDIT       995  largest credit in cents; a coin that would exceed it is rejected
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous, active-low reset
//  sensQ         in   1   raw quarter sensor level; async, bouncy
//  sensD         in   1   raw dime sensor level
//  sensN         in   1   raw nickel sensor level
//  inhibit       in   1   1 = reject every coin emitted while high
//  clear_credit  in   1   1-cycle pulse that zeroes credit (driven with the counter reset)
//  outQ          out  1   1-cycle pulse: quarter accepted (to coin counter inQ)
//  outD          out  1   1-cycle pulse: dime accepted
//  outN          out  1   1-cycle pulse: nickel accepted
//  reject        out  1   1-cycle pulse: coin routed to the return chute
//  credit        out  10  running accepted value in cents
//  busy          out  1   high if any coin is pending or the FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst=0):
//   - All outputs are 0. credit=0. Synchronisers, debounce counters and pending counters clear.
//   - Reset is effective at any time, including mid-EMIT/GAP; pending coins are discarded.
//  Input conditioning (per channel):
//   - Two-flop synchroniser.
//   - Debounce counter: increments while the synchronised level is 1, clears when it is 0.
//   - An insertion event fires once, on the edge where the count reaches DEBOUNCE_CYCLES.
//   - The channel re-arms only after DEBOUNCE_CYCLES consecutive 0 samples.
//     A level held high therefore gives exactly one event.
//  Pending counters (per channel, 2 bits):
//   - An event increments the counter.
//   - If the counter is already 3, the event raises reject on the next free EMIT slot instead.
//  Output FSM:
//   - States: IDLE, EMIT, GAP.
//   - IDLE -> EMIT when any pending count is nonzero. Grant priority is Q > D > N.
//     The granted count decrements on that same edge.
//   - EMIT (1 cycle): exactly one of outQ/outD/outN/reject is high.
//     Reject is chosen if inhibit=1 or if credit+value > MAX_CREDIT; credit is then unchanged.
//     Otherwise credit <= credit + value, with value 25/10/5. Sum is 10 bits, no wrap by rule.
//   - EMIT -> GAP. GAP lasts GAP_CYCLES, then returns to IDLE.
//  Latency:
//   - Edge 0 is the first edge that samples the sensor high.
//   - With the FSM idle, the out pulse is high in the cycle after edge 2+DEBOUNCE_CYCLES
//     (edge 6 with defaults).
//   - Back-to-back pulses are spaced by 1+GAP_CYCLES cycles.
//  Simultaneous events:
//   - Coins on all three channels in one cycle are emitted Q, then D, then N, in separate EMITs.
//   - An event arriving during EMIT/GAP is held pending and is not lost.
//  clear_credit:
//   - Has priority. If it coincides with an accepting EMIT, credit <= value of that coin.
//   - Otherwise credit <= 0.
//  Other rules:
//   - inhibit is sampled only in EMIT. Debounce and pending continue while inhibited.
//   - busy is combinational: (state != IDLE) || any pending count != 0.
// TESTING
//  1. Reset, then sensQ high for 10 cycles with 3-cycle bounce at the start
//     -> exactly one outQ pulse, credit=25, busy low afterwards.
//  2. sensQ, sensD, sensN rise in the same cycle
//     -> outQ, outD, outN on separate cycles 2 apart (GAP=1), credit=40.
//  3. Credit 980, insert quarter -> reject pulse, no outQ, credit stays 980.
//     Then insert nickel -> outN, credit=985.
//  4. inhibit=1, insert dime -> reject, credit unchanged.
//     inhibit=0, insert dime -> outD, credit +10.
//  5. clear_credit pulsed in the same cycle as an outN EMIT with credit=100 -> credit=5.
//  6. rst driven low during GAP with two dimes pending
//     -> all outputs 0 immediately; after release, no outD is emitted and credit=0.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if
//   Bundles the coin-path signals between the sensor front end and its user.
//   master: drives the raw sensor levels, inhibit and clear_credit and observes the results.
//   slave : the coin_acceptor itself.
//   Signals:
//     sensQ/sensD/sensN  raw, bouncy, asynchronous sensor levels
//     inhibit            1 = every coin emitted while high is rejected
//     clear_credit       1-cycle pulse that zeroes credit
//     outQ/outD/outN     1-cycle accepted-coin pulses
//     reject             1-cycle pulse: coin goes to the return chute
//     credit[9:0]        running accepted value in cents
//     busy               a coin is pending or the output FSM is not idle
interface coin_acceptor_if;
   logic       sensQ;
   logic       sensD;
   logic       sensN;
   logic       inhibit;
   logic       clear_credit;
   logic       outQ;
   logic       outD;
   logic       outN;
   logic       reject;
   logic [9:0] credit;
   logic       busy;

   modport master (
      output sensQ, sensD, sensN, inhibit, clear_credit,
      input  outQ, outD, outN, reject, credit, busy
   );

   modport slave (
      input  sensQ, sensD, sensN, inhibit, clear_credit,
      output outQ, outD, outN, reject, credit, busy
   );
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Front end of the coin path: synchronises and debounces three raw coin sensors,
//   queues insertion events per channel, and emits them one at a time as clean
//   single-cycle outQ/outD/outN/reject pulses while tracking accepted credit.
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-low reset
//     bus   coin_acceptor_if.slave (sensors, inhibit, clear_credit in; pulses, credit, busy out)
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GAP_CYCLES      = 1,
   parameter int MAX_CREDIT      = 995
) (
   input logic             clk,
   input logic             rst,
   coin_acceptor_if.slave  bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;
   // Channel index doubles as grant code: 0=Q, 1=D, 2=N.
   typedef enum logic [1:0] {G_Q, G_D, G_N, G_REJ} grant_t;

   logic [2:0]  sens;
   logic [2:0]  ev;
   logic [2:0]  ovf;
   logic [1:0]  pend_q [3];
   logic [1:0]  pend_d [3];
   logic [1:0]  rej_pend_q;   // overflow rejects still waiting for an EMIT slot
   logic [1:0]  rej_pend_d;
   logic [3:0]  rej_sum;
   state_t      state_q;
   grant_t      gnt_q;
   grant_t      gnt_d;
   logic [GW-1:0] gap_q;
   logic [9:0]  credit_q;
   logic [9:0]  coin_val;
   logic [10:0] credit_sum;
   logic        any_pend;
   logic        slot_free;
   logic        take;
   logic        emit;
   logic        accept;

   assign sens = {bus.sensN, bus.sensD, bus.sensQ};

   // Per-channel conditioning: 2-flop sync, high/low run counters, one event per insertion.
   for (genvar g = 0; g < 3; g++) begin : g_ch
      logic          sync1_q;
      logic          sync2_q;
      logic          armed_q;
      logic [DW-1:0] hi_q;
      logic [DW-1:0] lo_q;

      // Fires on the edge where the high run reaches DEBOUNCE_CYCLES.
      assign ev[g] = armed_q & sync2_q & (hi_q == DB_LAST);

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            armed_q <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
         end else begin
            sync1_q <= sens[g];
            sync2_q <= sync1_q;
            if (sync2_q) begin
               lo_q <= '0;
               if (hi_q != DB_MAX) hi_q <= hi_q + DW'(1);
            end else begin
               hi_q <= '0;
               if (lo_q != DB_MAX) lo_q <= lo_q + DW'(1);
            end
            // Disarm after the event; re-arm only after a full low run.
            if (ev[g])                              armed_q <= 1'b0;
            else if (!sync2_q && lo_q == DB_LAST)   armed_q <= 1'b1;
         end
      end
   end

   // A new grant can be taken from IDLE, or straight out of the last GAP cycle so that
   // back-to-back pulses are spaced exactly 1+GAP_CYCLES apart.
   assign any_pend  = (rej_pend_q != 2'd0) || (pend_q[0] != 2'd0) ||
                      (pend_q[1] != 2'd0) || (pend_q[2] != 2'd0);
   assign slot_free = (state_q == IDLE) || (state_q == GAP && gap_q == '0);
   assign take      = slot_free && any_pend;

   always_comb begin
      gnt_d = G_REJ;
      if (rej_pend_q != 2'd0)     gnt_d = G_REJ;
      else if (pend_q[0] != 2'd0) gnt_d = G_Q;
      else if (pend_q[1] != 2'd0) gnt_d = G_D;
      else                        gnt_d = G_N;
   end

   // Pending update: grant decrements first, so an event on a full counter that is
   // being drained on the same edge still fits.
   always_comb begin
      ovf = '0;
      for (int c = 0; c < 3; c++) begin
         pend_d[c] = pend_q[c];
         if (take && gnt_d == grant_t'(c)) pend_d[c] = pend_d[c] - 2'd1;
         if (ev[c]) begin
            if (pend_d[c] == 2'd3) ovf[c]    = 1'b1;
            else                   pend_d[c] = pend_d[c] + 2'd1;
         end
      end
      rej_sum = 4'(rej_pend_q) + 4'(ovf[0]) + 4'(ovf[1]) + 4'(ovf[2])
                - 4'(take && gnt_d == G_REJ);
      rej_pend_d = (rej_sum > 4'd3) ? 2'd3 : rej_sum[1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < 3; c++) pend_q[c] <= 2'd0;
         rej_pend_q <= 2'd0;
      end else begin
         for (int c = 0; c < 3; c++) pend_q[c] <= pend_d[c];
         rej_pend_q <= rej_pend_d;
      end
   end

   // EMIT decision: inhibit and the credit ceiling are evaluated during the EMIT cycle.
   assign emit = (state_q == EMIT);

   always_comb begin
      coin_val = 10'd0;
      case (gnt_q)
         G_Q:     coin_val = 10'd25;
         G_D:     coin_val = 10'd10;
         G_N:     coin_val = 10'd5;
         default: coin_val = 10'd0;
      endcase
   end

   assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
   assign accept     = emit && (gnt_q != G_REJ) && !bus.inhibit &&
                       (credit_sum <= 11'(MAX_CREDIT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         gnt_q    <= G_Q;
         gap_q    <= '0;
         credit_q <= 10'd0;
      end else begin
         case (state_q)
            IDLE: if (any_pend) begin
               state_q <= EMIT;
               gnt_q   <= gnt_d;
            end
            EMIT: begin
               state_q <= GAP;
               gap_q   <= GAP_LOAD;
            end
            GAP: begin
               if (gap_q != '0) gap_q <= gap_q - GW'(1);
               else if (any_pend) begin
                  state_q <= EMIT;
                  gnt_q   <= gnt_d;
               end else state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         // clear_credit wins, but a coin accepted on the same edge still counts.
         if (bus.clear_credit) credit_q <= accept ? coin_val : 10'd0;
         else if (accept)      credit_q <= credit_sum[9:0];
      end
   end

   assign bus.outQ   = accept && (gnt_q == G_Q);
   assign bus.outD   = accept && (gnt_q == G_D);
   assign bus.outN   = accept && (gnt_q == G_N);
   assign bus.reject = emit && !accept;
   assign bus.credit = credit_q;
   assign bus.busy   = (state_q != IDLE) || any_pend;
endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;
   localparam int D   = 4;
   localparam int GAP = 1;
   localparam int MAX = 995;

   logic clk;
   logic rst;
   coin_acceptor_if bus();

   coin_acceptor #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(GAP), .MAX_CREDIT(MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int nq = 0, nd = 0, nn = 0, nr = 0;

   always @(negedge clk) begin
      if (bus.outQ)   nq++;
      if (bus.outD)   nd++;
      if (bus.outN)   nn++;
      if (bus.reject) nr++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic set_sens(input int ch, input logic v);
      case (ch)
         0: bus.sensQ = v;
         1: bus.sensD = v;
         default: bus.sensN = v;
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.sensQ = 0; bus.sensD = 0; bus.sensN = 0;
      bus.inhibit = 0; bus.clear_credit = 0;
      #1;
      check("reset pulses", {bus.outQ, bus.outD, bus.outN, bus.reject}, 0);
      check("reset credit", bus.credit, 0);
      check("reset busy", bus.busy, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One clean insertion on a channel; returns the pulse counts it produced.
   task automatic insert(input int ch, output int q, output int d, output int n, output int r);
      int q0, d0, n0, r0;
      #1;
      q0 = nq; d0 = nd; n0 = nn; r0 = nr;
      set_sens(ch, 1'b1);
      repeat (8) @(negedge clk);
      set_sens(ch, 1'b0);
      repeat (12) @(negedge clk);
      #1;
      q = nq - q0; d = nd - d0; n = nn - n0; r = nr - r0;
   endtask

   // ---------------- behavioural reference model ----------------
   int m_s1[3], m_s2[3], m_hi[3], m_lo[3], m_pend[3];
   bit m_arm[3];
   int m_rej, m_emit, m_gap, m_credit;

   function automatic int coin_value(input int ch);
      case (ch)
         0: return 25;
         1: return 10;
         2: return 5;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_accept();
      return (m_emit >= 0) && (m_emit < 3) && !bus.inhibit &&
             (m_credit + coin_value(m_emit) <= MAX);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         m_s1[c] = 0; m_s2[c] = 0; m_hi[c] = 0; m_lo[c] = 0; m_pend[c] = 0; m_arm[c] = 1;
      end
      m_rej = 0; m_emit = -1; m_gap = 0; m_credit = 0;
   endtask

   function automatic logic [14:0] model_expect();
      bit acc;
      bit bsy;
      acc = m_accept();
      bsy = (m_emit >= 0) || (m_gap > 0) || (m_rej > 0) ||
            (m_pend[0] + m_pend[1] + m_pend[2] > 0);
      return {acc && m_emit == 0, acc && m_emit == 1, acc && m_emit == 2,
              (m_emit >= 0) && !acc, bsy, 10'(m_credit)};
   endfunction

   // Advance the model across one rising edge using the inputs of the current cycle.
   task automatic model_step();
      bit acc, free;
      bit ev[3];
      int grant, in_now[3];
      acc = m_accept();
      if (bus.clear_credit) m_credit = acc ? coin_value(m_emit) : 0;
      else if (acc)         m_credit = m_credit + coin_value(m_emit);
      in_now[0] = bus.sensQ; in_now[1] = bus.sensD; in_now[2] = bus.sensN;
      for (int c = 0; c < 3; c++) begin
         int seen;
         seen = m_s2[c];          // level sampled two edges ago
         m_s2[c] = m_s1[c];
         m_s1[c] = in_now[c];
         if (seen != 0) begin m_hi[c]++; m_lo[c] = 0; end
         else           begin m_lo[c]++; m_hi[c] = 0; end
         ev[c] = m_arm[c] && (m_hi[c] == D);
         if (ev[c]) m_arm[c] = 0;
         if (m_lo[c] == D) m_arm[c] = 1;
      end
      free = 0;
      if (m_emit >= 0) begin m_emit = -1; m_gap = GAP; end
      else if (m_gap > 0) begin m_gap--; free = (m_gap == 0); end
      else free = 1;
      grant = -1;
      if (free) begin
         if (m_rej > 0)          grant = 3;
         else if (m_pend[0] > 0) grant = 0;
         else if (m_pend[1] > 0) grant = 1;
         else if (m_pend[2] > 0) grant = 2;
         if (grant == 3) m_rej--;
         else if (grant >= 0) m_pend[grant]--;
         m_emit = grant;
      end
      for (int c = 0; c < 3; c++)
         if (ev[c]) begin
            if (m_pend[c] == 3) m_rej = (m_rej < 3) ? m_rej + 1 : 3;
            else m_pend[c]++;
         end
   endtask

   // ---------------- directed table: bounce then long hold ----------------
   typedef struct {
      logic sens;
      logic exp_out;
      int   exp_credit;
      logic exp_busy;
   } vec_t;
   vec_t tbl[16];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int q, d, n, r, tq, td, tn, found;
      logic [14:0] got, exp;

      tbl = '{'{1'b1, 1'b0, 0, 1'b0}, '{1'b0, 1'b0, 0, 1'b0}, '{1'b1, 1'b0, 0, 1'b0},
              '{1'b1, 1'b0, 0, 1'b0}, '{1'b1, 1'b0, 0, 1'b0}, '{1'b1, 1'b0, 0, 1'b0},
              '{1'b1, 1'b0, 0, 1'b0}, '{1'b1, 1'b0, 0, 1'b1}, '{1'b1, 1'b1, 0, 1'b1},
              '{1'b1, 1'b0, 25, 1'b1}, '{1'b1, 1'b0, 25, 1'b0}, '{1'b1, 1'b0, 25, 1'b0},
              '{1'b1, 1'b0, 25, 1'b0}, '{1'b0, 1'b0, 25, 1'b0}, '{1'b0, 1'b0, 25, 1'b0},
              '{1'b0, 1'b0, 25, 1'b0}};

      // Test 1: bouncy quarter held high
      do_reset();
      for (int k = 0; k < 16; k++) begin
         bus.sensQ = tbl[k].sens;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("t1[%0d] pulses", k), {bus.outQ, bus.outD, bus.outN, bus.reject},
               {tbl[k].exp_out, 3'b000});
         check($sformatf("t1[%0d] credit", k), bus.credit, tbl[k].exp_credit);
         check($sformatf("t1[%0d] busy", k), bus.busy, tbl[k].exp_busy);
      end

      // Test 2: all three channels rise together
      do_reset();
      repeat (2) @(negedge clk);
      bus.sensQ = 1; bus.sensD = 1; bus.sensN = 1;
      tq = -1; td = -1; tn = -1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.outQ && tq < 0) tq = i;
         if (bus.outD && td < 0) td = i;
         if (bus.outN && tn < 0) tn = i;
         if (int'(bus.outQ) + int'(bus.outD) + int'(bus.outN) + int'(bus.reject) > 1)
            check("t2 one-hot", {bus.outQ, bus.outD, bus.outN, bus.reject}, 0);
      end
      check("t2 Q latency", tq, 2 + D);
      check("t2 Q->D spacing", td - tq, 1 + GAP);
      check("t2 D->N spacing", tn - td, 1 + GAP);
      check("t2 credit", bus.credit, 40);
      check("t2 busy", bus.busy, 0);
      bus.sensQ = 0; bus.sensD = 0; bus.sensN = 0;
      repeat (10) @(negedge clk);

      // Test 3/4: credit ceiling and inhibit
      do_reset();
      for (int i = 0; i < 39; i++) insert(0, q, d, n, r);
      insert(2, q, d, n, r);
      check("t3 credit 980", bus.credit, 980);
      insert(0, q, d, n, r);
      check("t3 Q over max rejected", {q[7:0], r[7:0]}, {8'd0, 8'd1});
      check("t3 credit held", bus.credit, 980);
      insert(2, q, d, n, r);
      check("t3 N accepted", {n[7:0], r[7:0]}, {8'd1, 8'd0});
      check("t3 credit 985", bus.credit, 985);
      bus.inhibit = 1;
      insert(1, q, d, n, r);
      check("t4 inhibited D", {d[7:0], r[7:0]}, {8'd0, 8'd1});
      check("t4 credit held", bus.credit, 985);
      bus.inhibit = 0;
      insert(1, q, d, n, r);
      check("t4 D to max", {d[7:0], r[7:0]}, {8'd1, 8'd0});
      check("t4 credit 995", bus.credit, 995);
      insert(2, q, d, n, r);
      check("t4 N over max", {n[7:0], r[7:0]}, {8'd0, 8'd1});
      check("t4 credit still 995", bus.credit, 995);

      // Test 5: clear_credit coinciding with an accepting EMIT
      do_reset();
      for (int i = 0; i < 4; i++) insert(0, q, d, n, r);
      check("t5 credit 100", bus.credit, 100);
      bus.sensN = 1;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.outN) begin found = 1; break; end
      end
      check("t5 outN seen", found, 1);
      bus.clear_credit = 1;
      @(posedge clk);
      @(negedge clk);
      bus.clear_credit = 0;
      bus.sensN = 0;
      check("t5 clear+accept", bus.credit, 5);
      bus.clear_credit = 1;
      @(posedge clk);
      @(negedge clk);
      bus.clear_credit = 0;
      check("t5 plain clear", bus.credit, 0);
      repeat (10) @(negedge clk);

      // Test 6: reset during GAP with coins pending
      do_reset();
      repeat (2) @(negedge clk);
      bus.sensQ = 1; bus.sensD = 1; bus.sensN = 1;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.outQ) begin found = 1; break; end
      end
      check("t6 outQ seen", found, 1);
      @(negedge clk);
      check("t6 busy in gap", bus.busy, 1);
      check("t6 credit before rst", bus.credit, 25);
      rst = 0;
      bus.sensQ = 0; bus.sensD = 0; bus.sensN = 0;
      #1;
      check("t6 async pulses", {bus.outQ, bus.outD, bus.outN, bus.reject}, 0);
      check("t6 async credit", bus.credit, 0);
      check("t6 async busy", bus.busy, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1;
      #1;
      q = nq; d = nd; n = nn; r = nr;
      repeat (30) @(negedge clk);
      #1;
      check("t6 nothing after rst", (nq - q) + (nd - d) + (nn - n) + (nr - r), 0);
      check("t6 credit after rst", bus.credit, 0);

      // Randomised run against the reference model
      do_reset();
      model_reset();
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) bus.sensQ = ~bus.sensQ;
         if ($urandom_range(0, 7) == 0) bus.sensD = ~bus.sensD;
         if ($urandom_range(0, 7) == 0) bus.sensN = ~bus.sensN;
         if ($urandom_range(0, 29) == 0) bus.inhibit = ~bus.inhibit;
         bus.clear_credit = ($urandom_range(0, 299) == 0);
         #1;
         exp = model_expect();
         got = {bus.outQ, bus.outD, bus.outN, bus.reject, bus.busy, bus.credit};
         check($sformatf("rand[%0d] QDNR-busy-credit", i), 32'(got), 32'(exp));
         model_step();
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
